clock_div_prog: RTL and testbench
=================================

# clock_div_prog

Parametrised, multi-channel programmable clock-enable generator, the successor to the team's fixed 8-bit free-running divider. It keeps a WIDTH-bit free-running count output and adds NCH independent channels. Each channel has a runtime-programmable divisor, a one-cycle tick strobe and a 50%-duty square output. Divisor changes are glitch-free, and a sync input phase-aligns all channels. It sits between the fabric clock and downstream blocks that need slower enables (PWM, UART baud, LED scan). It never generates derived clocks; all outputs are synchronous to clk.

## Interface
- WIDTH, 8: width of every counter, divisor and q; legal 2..32.
- NCH, 4: number of divider channels; legal 1..16.
- DIV_RESET, 2: divisor loaded into every channel at reset; must be < 2^WIDTH.
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global count enable.
- sync  in  1  synchronous phase-align pulse.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  max(1,$clog2(NCH))  channel index for the write.
- wr_data  in  WIDTH  new divisor value.
- q  out  WIDTH  free-running count.
- tick  out  NCH  per-channel one-cycle enable strobe.
- sq  out  NCH  per-channel square wave at f_clk/(2N).
- pend  out  NCH  per-channel flag: a divisor write is waiting for terminal count.

## Operation
- Reset (rst=0, asynchronous) values: q=0, tick=0, sq=0, pend=0. Internally every channel count cnt=0, active divisor div=DIV_RESET and shadow=0.
- Input priority is rst > sync > en.
- q increments by 1 on each edge with en=1, wraps 2^WIDTH-1 -> 0 and holds when en=0.
- Channel with divisor N ≥ 1 and en=1:
  - cnt counts 0..N-1 and wraps.
  - Terminal count (TC) is cnt==N-1.
  - On a TC edge, tick is registered to 1 for exactly one cycle and sq toggles.
  - tick period is N enabled cycles. sq period is 2N, duty 50%.
- N=1: tick stays high on every enabled cycle; sq toggles every cycle.
- N=0: the channel is disabled. cnt is held at 0, tick=0 and sq holds its value.
- en=0: all cnt and sq hold, all tick=0. Writes are still accepted.
- Divisor write (wr_en=1, wr_ch=c, wr_ch < NCH):
  - If channel c is disabled (div=0), div<=wr_data on that edge, with no pend.
  - Otherwise shadow<=wr_data and pend[c]<=1. At the next TC, div<=shadow and pend[c]<=0.
  - A second write while pending overwrites the shadow; the last write wins.
  - A write on the same edge as a TC of that channel bypasses the shadow: div<=wr_data, pend[c]<=0.
  - Writes with wr_ch ≥ NCH are ignored.
- sync=1, regardless of en:
  - q, all cnt, tick and sq go to 0.
  - Every pending shadow is applied (div<=shadow) and pend is cleared.
  - A write on the same edge is applied directly to div.
- The N-1 comparison is done in WIDTH bits; N=0 is decoded separately and never wraps to all-ones.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- After rst deasserts with en=1 and divisor N, the first tick is high following the Nth rising edge. It repeats every N edges.
- sq rises on the same edge as the first tick.
- pend goes high the edge after the write and falls on the TC edge that applies the shadow. The new period starts with cnt=0 on that edge.
- A disabled channel written with N starts counting the edge after the write. Its first tick follows N further edges.
- After sync, the first tick of every channel with divisor N follows the Nth subsequent enabled edge. This makes equal-divisor channels phase-aligned.
- en deasserted mid-period freezes the phase. Counting resumes exactly where it stopped.
- Asserting rst mid-operation clears everything immediately, without waiting for clk. Pending writes are lost and div returns to DIV_RESET.

## Test plan
- Reset defaults: rst=0, then release with en=1 and all channels at DIV_RESET=2. Required: q=0 and tick=sq=pend=0 during reset; tick[*] pulses every 2nd cycle; sq toggles every 2 cycles; q counts 0,1,2...
- Wrap: WIDTH=8, en=1 for 260 cycles. Required: q goes 255 -> 0. A channel with N=255 ticks exactly every 255 cycles.
- Deferred write: ch0 running N=4, write wr_data=6 with cnt=1. Required: pend[0]=1 until TC, then the remaining 4-cycle period completes, then period 6 follows. A second write of 3 before TC gives period 3 instead.
- Simultaneous write and TC: write 5 to ch1 on its TC edge. Required: pend[1] never rises and the next period is 5.
- Edge divisors: write 1 to ch2. Required: tick[2] constantly high and sq[2] toggling every cycle. Then write 0. Required: tick[2]=0 and sq[2] frozen. Then write 3. Required: first tick 3 edges after the counting start.
- sync/en/reset: run ch0 at N=3 and ch1 at N=3 out of phase, pulse sync. Required: ticks coincide thereafter. Then hold en=0 for 5 cycles. Required: tick=0 and q/sq frozen, and the phase resumes. Then assert rst asynchronously mid-period. Required: outputs clear before the next clk edge.

Source files
------------

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock-enable generator: free-running count plus NCH
// independent divider channels with tick strobes, square outputs and glitch-free divisor updates.
module clock_div_prog #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NCH       = 4,
    parameter int unsigned DIV_RESET = 2,
    localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] q,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq,
    output logic [NCH-1:0]   pend
);

    logic [WIDTH-1:0]            q_q, q_d;
    logic [NCH-1:0][WIDTH-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0][WIDTH-1:0]   div_q, div_d;
    logic [NCH-1:0][WIDTH-1:0]   shd_q, shd_d;
    logic [NCH-1:0]              tick_q, tick_d;
    logic [NCH-1:0]              sq_q, sq_d;
    logic [NCH-1:0]              pend_q, pend_d;

    logic                        wr_ok_c;
    logic [NCH-1:0]              hit_c;
    logic [NCH-1:0]              off_c;
    logic [NCH-1:0]              tc_c;

    // Per-channel decode: write target, disabled (N=0) and terminal count
    always_comb begin
        hit_c   = '0;
        off_c   = '0;
        tc_c    = '0;
        wr_ok_c = wr_en && (32'(wr_ch) < NCH);
        for (int c = 0; c < NCH; c++) begin
            hit_c[c] = wr_ok_c && (wr_ch == CHW'(c));
            off_c[c] = (div_q[c] == '0);
            tc_c[c]  = en && !off_c[c] && (cnt_q[c] == (div_q[c] - WIDTH'(1)));
        end
    end

    // Next-state: sync dominates en; divisor updates only land on a period boundary
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        shd_d  = shd_q;
        tick_d = '0;
        sq_d   = sq_q;
        pend_d = pend_q;

        if (sync) begin
            q_d = '0;
        end else if (en) begin
            q_d = q_q + WIDTH'(1);
        end

        for (int c = 0; c < NCH; c++) begin
            if (sync) begin
                cnt_d[c]  = '0;
                sq_d[c]   = 1'b0;
                pend_d[c] = 1'b0;
                if (hit_c[c]) begin
                    div_d[c] = wr_data;
                end else if (pend_q[c]) begin
                    div_d[c] = shd_q[c];
                end
            end else begin
                if (off_c[c]) begin
                    cnt_d[c] = '0;
                end else if (en) begin
                    cnt_d[c] = tc_c[c] ? '0 : cnt_q[c] + WIDTH'(1);
                end
                if (tc_c[c]) begin
                    tick_d[c] = 1'b1;
                    sq_d[c]   = ~sq_q[c];
                end
                // A write on a TC edge or to an idle channel skips the shadow
                if (hit_c[c]) begin
                    if (off_c[c] || tc_c[c]) begin
                        div_d[c]  = wr_data;
                        pend_d[c] = 1'b0;
                    end else begin
                        shd_d[c]  = wr_data;
                        pend_d[c] = 1'b1;
                    end
                end else if (tc_c[c] && pend_q[c]) begin
                    div_d[c]  = shd_q[c];
                    pend_d[c] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            cnt_q  <= '0;
            shd_q  <= '0;
            tick_q <= '0;
            sq_q   <= '0;
            pend_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                div_q[c] <= WIDTH'(DIV_RESET);
            end
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            shd_q  <= shd_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
            pend_q <= pend_d;
        end
    end

    assign q    = q_q;
    assign tick = tick_q;
    assign sq   = sq_q;
    assign pend = pend_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// Scoreboard bench for clock_div_prog: stimulus pushes model predictions, a monitor
// pops and compares them one clock later.
module tb_clock_div_prog;

    localparam int unsigned W   = 8;
    localparam int unsigned NC  = 4;
    localparam int unsigned DR  = 2;
    localparam int unsigned CHW = 2;

    typedef struct packed {
        logic [W-1:0]  q;
        logic [NC-1:0] tick;
        logic [NC-1:0] sq;
        logic [NC-1:0] pend;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0;
    logic           sync = 1'b0;
    logic           wr_en = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [W-1:0]   wr_data = '0;
    logic [W-1:0]   q;
    logic [NC-1:0]  tick, sq, pend;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t sb[$];

    // Reference model state (values after the most recently modelled edge)
    int m_q;
    int m_cnt[NC], m_div[NC], m_shd[NC];
    bit m_tick[NC], m_sq[NC], m_pend[NC];

    clock_div_prog #(.WIDTH(W), .NCH(NC), .DIV_RESET(DR)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_data(wr_data), .q(q), .tick(tick), .sq(sq), .pend(pend)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0;
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = 0; m_div[c] = DR; m_shd[c] = 0;
            m_tick[c] = 0; m_sq[c] = 0; m_pend[c] = 0;
        end
    endtask

    // One rising edge of the behavioural model
    task automatic model_step(input bit e, input bit s, input bit we, input int ch, input int d);
        bit hit, tc, idle;
        if (s) begin
            m_q = 0;
            for (int c = 0; c < NC; c++) begin
                hit = we && (ch == c);
                m_cnt[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
                if (hit) m_div[c] = d;
                else if (m_pend[c]) m_div[c] = m_shd[c];
                m_pend[c] = 0;
            end
        end else begin
            if (e) m_q = (m_q + 1) % (1 << W);
            for (int c = 0; c < NC; c++) begin
                hit  = we && (ch == c);
                idle = (m_div[c] == 0);
                tc   = e && !idle && (m_cnt[c] == m_div[c] - 1);
                m_tick[c] = tc;
                if (e && !idle) m_cnt[c] = (m_cnt[c] + 1) % m_div[c];
                if (tc) m_sq[c] = !m_sq[c];
                if (hit) begin
                    if (idle || tc) begin m_div[c] = d; m_pend[c] = 0; end
                    else begin m_shd[c] = d; m_pend[c] = 1; end
                end else if (tc && m_pend[c]) begin
                    m_div[c] = m_shd[c]; m_pend[c] = 0;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.q = W'(m_q);
        for (int c = 0; c < NC; c++) begin
            x.tick[c] = m_tick[c]; x.sq[c] = m_sq[c]; x.pend[c] = m_pend[c];
        end
        return x;
    endfunction

    task automatic cyc(input bit e, input bit s, input bit we, input int ch, input int d);
        @(negedge clk);
        en = e; sync = s; wr_en = we; wr_ch = CHW'(ch); wr_data = W'(d);
        model_step(e, s, we, ch, d);
        sb.push_back(model_out());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_q"}, 32'(q), 32'd0);
        chk({tag, "_tick"}, 32'(tick), 32'd0);
        chk({tag, "_sq"}, 32'(sq), 32'd0);
        chk({tag, "_pend"}, 32'(pend), 32'd0);
    endtask

    // Monitor: every edge the DUT presents a fresh output set
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("q", 32'(q), 32'(x.q));
                chk("tick", 32'(tick), 32'(x.tick));
                chk("sq", 32'(sq), 32'(x.sq));
                chk("pend", 32'(pend), 32'(x.pend));
            end
        end
    end

    initial begin
        int k;
        model_reset();
        #3;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #3;
        chk_zero("reset_held");
        @(posedge clk);
        #2 rst = 1'b1;

        // Default divisor 2 on all channels
        run(10);

        // Deferred write of 6 to ch0 after moving it to N=4
        cyc(1, 0, 1, 0, 4);
        k = 0;
        while (!(m_cnt[0] == 1 && !m_pend[0] && m_div[0] == 4) && k < 50) begin run(1); k++; end
        chk("wait_ch0_cnt1", 32'(k < 50), 32'd1);
        cyc(1, 0, 1, 0, 6);
        run(20);
        // Second write before TC overrides the shadow
        k = 0;
        while (!(m_cnt[0] == 1) && k < 50) begin run(1); k++; end
        cyc(1, 0, 1, 0, 4);
        cyc(1, 0, 1, 0, 3);
        run(16);

        // Write landing exactly on ch1 TC bypasses the shadow
        cyc(1, 0, 1, 1, 7);
        run(10);
        k = 0;
        while (!(m_cnt[1] == m_div[1] - 1 && !m_pend[1]) && k < 50) begin run(1); k++; end
        chk("wait_ch1_tc", 32'(k < 50), 32'd1);
        cyc(1, 0, 1, 1, 5);
        run(12);

        // Edge divisors on ch2: 1, 0, then 3
        cyc(1, 0, 1, 2, 1);
        run(8);
        k = 0;
        while (m_pend[2] && k < 50) begin run(1); k++; end
        cyc(1, 0, 1, 2, 0);
        run(8);
        cyc(1, 0, 1, 2, 3);
        run(8);

        // N=255 on ch3 across a q wrap
        cyc(1, 0, 1, 3, 255);
        run(520);

        // Out-of-phase N=3 channels realigned by sync, then frozen by en=0
        cyc(1, 0, 1, 0, 3);
        run(2);
        cyc(1, 0, 1, 1, 3);
        run(7);
        cyc(1, 1, 0, 0, 0);
        run(9);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        run(7);
        cyc(0, 0, 1, 2, 5);
        cyc(0, 1, 0, 0, 0);
        run(6);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 8) != 0, ($urandom % 100) == 0, ($urandom % 10) == 0,
                int'($urandom % NC), int'($urandom % 9));
        end

        // Asynchronous reset mid-period
        cyc(1, 0, 1, 0, 7);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1 chk_zero("rst_low_edge");
        #1 rst = 1'b1;
        run(12);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
